// File: rtl/ace_snoop_initiator.sv
// ACE snoop initiator: issues one AC snoop per upstream command, gathers CR plus the optional
// two-beat CD line, and returns a single assembled result with filtering, protocol checks and a timeout.
module ace_snoop_initiator #(
  parameter int unsigned TimeoutCycles = 256,
  parameter int unsigned LineWidth     = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [63:0]          req_addr_i,
  input  logic [3:0]           req_snoop_i,
  // snoop_req_o  = {ac_valid, ac_addr[63:0], ac_snoop[3:0], cr_ready, cd_ready}
  output logic [70:0]          snoop_req_o,
  // snoop_resp_i = {ac_ready, cr_valid, cr_resp[3:0] = {isShared, passDirty, error, dataTransfer},
  //                 cd_valid, cd_data[63:0], cd_last}
  input  logic [71:0]          snoop_resp_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [LineWidth-1:0] rsp_data_o,
  output logic                 rsp_has_data_o,
  output logic                 rsp_pass_dirty_o,
  output logic                 rsp_is_shared_o,
  output logic                 rsp_error_o,
  output logic                 busy_o
);
  // Every channel transfers on a cycle where both valid and ready are high at posedge clk_i;
  // a valid, once raised, holds its payload stable until that handshake.
  typedef enum logic [1:0] {IDLE, SEND_AC, WAIT_RESP, DELIVER} state_e;

  localparam int unsigned BeatW = LineWidth / 2;

  state_e               state_q;
  logic [63:0]          addr_q;
  logic [3:0]           snoop_q;
  logic [1:0]           beat_cnt_q;
  logic                 cr_seen_q, dt_q, pd_q, is_q, err_q;
  logic [LineWidth-1:0] data_q;
  logic [31:0]          tmo_q;

  logic             ac_ready, cr_valid, cd_valid, cd_last;
  logic [3:0]       cr_resp;
  logic [BeatW-1:0] cd_data;

  assign ac_ready = snoop_resp_i[71];
  assign cr_valid = snoop_resp_i[70];
  assign cr_resp  = snoop_resp_i[69:66];
  assign cd_valid = snoop_resp_i[65];
  assign cd_data  = snoop_resp_i[64:1];
  assign cd_last  = snoop_resp_i[0];

  logic       cr_hs, cd_hs, cd_err, proto_err, done, tmo_hit;
  logic       cr_seen_d, dt_d, err_d;
  logic [1:0] beat_cnt_d;
  logic [31:0] tmo_d;

  function automatic logic snoop_supported(input logic [3:0] s);
    // ReadOnce, ReadShared, ReadUnique, CleanInvalid
    return (s == 4'b0000) || (s == 4'b0001) || (s == 4'b0111) || (s == 4'b1001);
  endfunction

  always_comb begin
    cr_hs      = 1'b0;
    cd_hs      = 1'b0;
    cd_err     = 1'b0;
    cr_seen_d  = cr_seen_q;
    dt_d       = dt_q;
    beat_cnt_d = beat_cnt_q;
    proto_err  = 1'b0;
    err_d      = err_q;
    done       = 1'b0;
    tmo_d      = tmo_q + 32'd1;
    tmo_hit    = 1'b0;
    if (state_q == WAIT_RESP) begin
      cr_hs      = cr_valid && !cr_seen_q;
      cd_hs      = cd_valid && (beat_cnt_q < 2'd2);
      cd_err     = cd_hs && (((beat_cnt_q == 2'd0) && cd_last) || ((beat_cnt_q == 2'd1) && !cd_last));
      cr_seen_d  = cr_seen_q || cr_hs;
      dt_d       = cr_hs ? cr_resp[0] : dt_q;
      beat_cnt_d = beat_cnt_q + {1'b0, cd_hs};
      // A line beat is illegal once CR has said no data will follow.
      proto_err  = cr_seen_d && !dt_d && (beat_cnt_d != 2'd0);
      err_d      = err_q || (cr_hs && cr_resp[1]) || cd_err || proto_err;
      done       = proto_err || (cr_seen_d && (dt_d ? (beat_cnt_d == 2'd2) : (beat_cnt_d == 2'd0)));
      tmo_hit    = (TimeoutCycles != 0) && (tmo_d == TimeoutCycles);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      snoop_q    <= '0;
      beat_cnt_q <= '0;
      cr_seen_q  <= 1'b0;
      dt_q       <= 1'b0;
      pd_q       <= 1'b0;
      is_q       <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      tmo_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q     <= req_addr_i & {{60{1'b1}}, 4'b0000};
            snoop_q    <= req_snoop_i;
            beat_cnt_q <= '0;
            cr_seen_q  <= 1'b0;
            dt_q       <= 1'b0;
            pd_q       <= 1'b0;
            is_q       <= 1'b0;
            data_q     <= '0;
            tmo_q      <= '0;
            err_q      <= !snoop_supported(req_snoop_i);
            state_q    <= snoop_supported(req_snoop_i) ? SEND_AC : DELIVER;
          end
        end
        SEND_AC: begin
          if (ac_ready) begin
            beat_cnt_q <= '0;
            cr_seen_q  <= 1'b0;
            tmo_q      <= '0;
            state_q    <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (cr_hs) begin
            dt_q <= cr_resp[0];
            pd_q <= cr_resp[2];
            is_q <= cr_resp[3];
          end
          if (cd_hs) begin
            if (beat_cnt_q == 2'd0) data_q[BeatW-1:0]         <= cd_data;
            else                    data_q[LineWidth-1:BeatW] <= cd_data;
          end
          cr_seen_q  <= cr_seen_d;
          beat_cnt_q <= beat_cnt_d;
          err_q      <= err_d;
          if (done) begin
            state_q <= DELIVER;
          end else begin
            tmo_q <= tmo_d;
            if (tmo_hit) begin
              err_q   <= 1'b1;
              state_q <= DELIVER;
            end
          end
        end
        DELIVER: begin
          if (rsp_ready_i) begin
            beat_cnt_q <= '0;
            cr_seen_q  <= 1'b0;
            dt_q       <= 1'b0;
            pd_q       <= 1'b0;
            is_q       <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o      = (state_q == IDLE);
  assign busy_o           = (state_q != IDLE);
  assign snoop_req_o      = {(state_q == SEND_AC), addr_q, snoop_q,
                             (state_q == WAIT_RESP) && !cr_seen_q,
                             (state_q == WAIT_RESP) && (beat_cnt_q < 2'd2)};
  assign rsp_valid_o      = (state_q == DELIVER);
  assign rsp_has_data_o   = dt_q && (beat_cnt_q == 2'd2) && !err_q;
  assign rsp_data_o       = rsp_has_data_o ? data_q : '0;
  assign rsp_pass_dirty_o = pd_q;
  assign rsp_is_shared_o  = is_q;
  assign rsp_error_o      = err_q;
endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Directed bench for ace_snoop_initiator: a driver issues commands and plays the snooped cache,
// expected results go into a queue that a monitor drains on every result handshake.
module tb_ace_snoop_initiator;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready;
  logic [63:0]  req_addr;
  logic [3:0]   req_snoop;
  logic [70:0]  snoop_req;
  logic [71:0]  snoop_resp;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_has_data, rsp_pass_dirty, rsp_is_shared, rsp_error, busy;

  logic         ac_ready, cr_valid, cd_valid, cd_last;
  logic [3:0]   cr_resp;
  logic [63:0]  cd_data;
  logic         ac_valid, cr_ready, cd_ready;
  logic [63:0]  ac_addr;
  logic [3:0]   ac_snoop;

  assign snoop_resp = {ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last};
  assign ac_valid   = snoop_req[70];
  assign ac_addr    = snoop_req[69:6];
  assign ac_snoop   = snoop_req[5:2];
  assign cr_ready   = snoop_req[1];
  assign cd_ready   = snoop_req[0];

  int n_checks = 0;
  int n_errors = 0;
  logic [131:0] exp_q[$];

  localparam logic [63:0] BEAT_A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BEAT_B = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] BEAT_C = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] BEAT_D = 64'hFEDC_BA98_7654_3210;

  ace_snoop_initiator #(.TimeoutCycles(8), .LineWidth(128)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_snoop_i(req_snoop),
    .snoop_req_o(snoop_req), .snoop_resp_i(snoop_resp),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_has_data_o(rsp_has_data),
    .rsp_pass_dirty_o(rsp_pass_dirty), .rsp_is_shared_o(rsp_is_shared),
    .rsp_error_o(rsp_error), .busy_o(busy)
  );

  // clock / reset-independent watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: one pop per result handshake
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 132'({rsp_data, rsp_has_data, rsp_pass_dirty, rsp_is_shared, rsp_error}), 132'd0);
      end else begin
        check("rsp", {rsp_data, rsp_has_data, rsp_pass_dirty, rsp_is_shared, rsp_error}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [63:0] addr, input logic [3:0] snoop);
    int n = 0;
    req_valid = 1'b1; req_addr = addr; req_snoop = snoop;
    while (!req_ready && n < 50) begin tick(); n++; end
    check("req_ready_wait", 132'(req_ready), 132'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ac_accept(input int hold, input logic [63:0] exp_addr, input logic [3:0] exp_snoop);
    int n = 0;
    while (!ac_valid && n < 50) begin tick(); n++; end
    check("ac_valid_wait", 132'(ac_valid), 132'd1);
    for (int i = 0; i < hold; i++) begin
      check("ac_stable", 132'({ac_valid, ac_addr, ac_snoop}), 132'({1'b1, exp_addr, exp_snoop}));
      tick();
    end
    check("ac_payload", 132'({ac_valid, ac_addr, ac_snoop}), 132'({1'b1, exp_addr, exp_snoop}));
    ac_ready = 1'b1;
    tick();
    ac_ready = 1'b0;
  endtask

  task automatic cr_send(input logic [3:0] resp);
    int n = 0;
    cr_valid = 1'b1; cr_resp = resp;
    while (!cr_ready && n < 50) begin tick(); n++; end
    check("cr_ready_wait", 132'(cr_ready), 132'd1);
    tick();
    cr_valid = 1'b0;
  endtask

  task automatic cd_send(input logic [63:0] data, input logic last);
    int n = 0;
    cd_valid = 1'b1; cd_data = data; cd_last = last;
    while (!cd_ready && n < 50) begin tick(); n++; end
    check("cd_ready_wait", 132'(cd_ready), 132'd1);
    tick();
    cd_valid = 1'b0; cd_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin tick(); n++; end
    check("idle_wait", 132'(busy), 132'd0);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_snoop = '0;
    ac_ready = 1'b0; cr_valid = 1'b0; cr_resp = '0; cd_valid = 1'b0; cd_data = '0; cd_last = 1'b0;
    repeat (3) tick();
    check("reset_state", 132'({req_ready, busy, rsp_valid, rsp_error, rsp_has_data, snoop_req}),
          132'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 71'd0}));
    rst_n = 1'b1;
    tick();

    // ReadShared hit: CR first, then two beats
    exp_q.push_back({BEAT_B, BEAT_A, 1'b1, 1'b0, 1'b1, 1'b0});
    send_req(64'h8000_1234, 4'b0001);
    check("ac_latency", 132'(ac_valid), 132'd1);
    ac_accept(0, 64'h8000_1230, 4'b0001);
    cr_send(4'b1001);
    cd_send(BEAT_A, 1'b0);
    cd_send(BEAT_B, 1'b1);
    wait_idle();

    // CleanInvalid miss: result the cycle after CR
    exp_q.push_back({128'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    send_req(64'h0000_0000_0000_0040, 4'b1001);
    ac_accept(0, 64'h40, 4'b1001);
    cr_send(4'b0000);
    check("miss_rsp_latency", 132'(rsp_valid), 132'd1);
    wait_idle();

    // Beats before CR, AC stalled four cycles
    exp_q.push_back({BEAT_D, BEAT_C, 1'b1, 1'b1, 1'b0, 1'b0});
    send_req(64'h1234_5678_9ABC_DEF7, 4'b0111);
    ac_accept(4, 64'h1234_5678_9ABC_DEF0, 4'b0111);
    cd_send(BEAT_C, 1'b0);
    cd_send(BEAT_D, 1'b1);
    repeat (3) tick();
    check("early_cd_wait", 132'({rsp_valid, cr_ready, cd_ready}), 132'({1'b0, 1'b1, 1'b0}));
    cr_send(4'b0101);
    wait_idle();

    // MakeInvalid is filtered: no AC, error result next cycle
    exp_q.push_back({128'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    send_req(64'h0000_0000_0000_0080, 4'b1101);
    check("filtered_rsp", 132'({ac_valid, rsp_valid, rsp_error}), 132'({1'b0, 1'b1, 1'b1}));
    wait_idle();

    // Timeout after 8 silent WAIT_RESP cycles
    rsp_ready = 1'b0;
    exp_q.push_back({128'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    send_req(64'h0000_0000_0000_0100, 4'b0000);
    ac_accept(0, 64'h100, 4'b0000);
    repeat (7) tick();
    check("timeout_not_yet", 132'({rsp_valid, cr_ready}), 132'({1'b0, 1'b1}));
    tick();
    check("timeout_fired", 132'({rsp_valid, rsp_error, rsp_has_data, cr_ready, cd_ready}),
          132'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    rsp_ready = 1'b1;
    wait_idle();

    // Beat0 flagged last is a protocol error
    exp_q.push_back({128'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    send_req(64'h0000_0000_0000_0200, 4'b0111);
    ac_accept(0, 64'h200, 4'b0111);
    cd_send(BEAT_A, 1'b1);
    cd_send(BEAT_B, 1'b1);
    cr_send(4'b0001);
    wait_idle();

    // Result held while rsp_ready is low, then reset mid-DELIVER
    rsp_ready = 1'b0;
    send_req(64'h0000_0000_0000_0300, 4'b0001);
    ac_accept(0, 64'h300, 4'b0001);
    cr_send(4'b1000);
    for (int i = 0; i < 5; i++) begin
      check("deliver_hold", 132'({rsp_valid, rsp_is_shared, rsp_has_data}), 132'({1'b1, 1'b1, 1'b0}));
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("post_reset", 132'({req_ready, busy, rsp_valid, rsp_error, rsp_is_shared, rsp_pass_dirty, rsp_has_data, rsp_data, snoop_req}),
          132'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'd0, 71'd0}));
    rsp_ready = 1'b1;
    tick();

    // Still functional after the reset
    exp_q.push_back({128'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    send_req(64'h0000_0000_0000_0400, 4'b1001);
    ac_accept(0, 64'h400, 4'b1001);
    cr_send(4'b0000);
    wait_idle();

    repeat (3) tick();
    check("queue_drained", 132'(exp_q.size()), 132'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
